// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: PS/2 keyboard receiver with show-ahead event FIFO.
//
// Synchronises ps2_clk/ps2_data, deframes 11-bit frames (start, 8 data LSB first,
// odd parity, stop), optionally folds E0/F0 prefixes into per-key flags and buffers
// the resulting events in a DEPTH-entry FIFO popped with a valid/rd_en handshake.
//
// Ports:
//   clk_i        system clock
//   clrn_i       asynchronous active-low reset (released synchronously internally)
//   ps2_clk_i    PS/2 clock, asynchronous
//   ps2_data_i   PS/2 data, asynchronous
//   rd_en_i      pop head entry; ignored while valid_o is low
//   clr_err_i    clears overflow_o / parity_err_o / frame_err_o
//   valid_o      FIFO non-empty
//   dout_o       head scan code (show-ahead); holds last value when empty
//   dout_brk_o   head entry is a key release (F0 seen)
//   dout_ext_o   head entry is extended (E0 seen)
//   level_o      FIFO occupancy, 0..DEPTH
//   overflow_o   sticky: event dropped because the FIFO was full
//   parity_err_o sticky: frame with bad odd parity
//   frame_err_o  sticky: bad start/stop bit or mid-frame timeout

module ps2_rx_fifo #(
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned SYNC_STAGES = 3,
    parameter int unsigned TIMEOUT     = 50000,
    parameter int unsigned DECODE      = 1
) (
    input  logic                   clk_i,
    input  logic                   clrn_i,
    input  logic                   ps2_clk_i,
    input  logic                   ps2_data_i,
    input  logic                   rd_en_i,
    input  logic                   clr_err_i,
    output logic                   valid_o,
    output logic [7:0]             dout_o,
    output logic                   dout_brk_o,
    output logic                   dout_ext_o,
    output logic [$clog2(DEPTH):0] level_o,
    output logic                   overflow_o,
    output logic                   parity_err_o,
    output logic                   frame_err_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {StIdle, StRecv, StCheck} state_e;

    // Reset synchroniser: assertion is immediate, release is aligned to clk_i.
    logic [1:0] rst_sync_q;
    logic       rst_n;

    always_ff @(posedge clk_i or negedge clrn_i) begin
        if (!clrn_i) rst_sync_q <= 2'b00;
        else         rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n = rst_sync_q[1];

    // Input synchronisers; index 0 is the first stage.
    logic [SYNC_STAGES-1:0] clk_sync_q, data_sync_q;
    logic                   fall, data_s;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync_q  <= '0;
            data_sync_q <= '0;
        end else begin
            clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk_i};
            data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data_i};
        end
    end

    assign fall   = clk_sync_q[SYNC_STAGES-1] & ~clk_sync_q[SYNC_STAGES-2];
    assign data_s = data_sync_q[SYNC_STAGES-1];

    // Deframer state
    state_e          state_q, state_d;
    logic [3:0]      bit_cnt_q, bit_cnt_d;
    logic [10:0]     frame_q, frame_d;
    logic [TW-1:0]   idle_cnt_q, idle_cnt_d;
    logic            ext_pend_q, ext_pend_d;
    logic            brk_pend_q, brk_pend_d;
    logic            push;
    logic [9:0]      push_entry;
    logic            par_set, frm_set;
    logic            start_ok, stop_ok, par_ok;
    logic [7:0]      rx_byte;

    assign rx_byte  = frame_q[8:1];
    assign start_ok = ~frame_q[0];
    assign stop_ok  = frame_q[10];
    assign par_ok   = ^frame_q[9:1];

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        frame_d    = frame_q;
        idle_cnt_d = idle_cnt_q;
        ext_pend_d = ext_pend_q;
        brk_pend_d = brk_pend_q;
        push       = 1'b0;
        push_entry = {2'b00, rx_byte};
        par_set    = 1'b0;
        frm_set    = 1'b0;
        unique case (state_q)
            StIdle: begin
                idle_cnt_d = '0;
                if (fall) begin
                    frame_d[0] = data_s;
                    bit_cnt_d  = 4'd1;
                    state_d    = StRecv;
                end
            end
            StRecv: begin
                if (fall) begin
                    frame_d[bit_cnt_q] = data_s;
                    idle_cnt_d         = '0;
                    if (bit_cnt_q == 4'd10) state_d = StCheck;
                    else                    bit_cnt_d = bit_cnt_q + 4'd1;
                end else if (idle_cnt_q == TW'(TIMEOUT - 1)) begin
                    // Stalled mid-frame: abandon it and any prefix it belonged to
                    frm_set    = 1'b1;
                    ext_pend_d = 1'b0;
                    brk_pend_d = 1'b0;
                    state_d    = StIdle;
                end else begin
                    idle_cnt_d = idle_cnt_q + TW'(1);
                end
            end
            StCheck: begin
                state_d = StIdle;
                par_set = ~par_ok;
                frm_set = ~start_ok | ~stop_ok;
                if (par_ok && start_ok && stop_ok) begin
                    if (DECODE != 0 && rx_byte == 8'hE0) begin
                        ext_pend_d = 1'b1;
                    end else if (DECODE != 0 && rx_byte == 8'hF0) begin
                        brk_pend_d = 1'b1;
                    end else begin
                        push = 1'b1;
                        if (DECODE != 0) push_entry = {ext_pend_q, brk_pend_q, rx_byte};
                        ext_pend_d = 1'b0;
                        brk_pend_d = 1'b0;
                    end
                end else begin
                    ext_pend_d = 1'b0;
                    brk_pend_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            bit_cnt_q  <= '0;
            frame_q    <= '0;
            idle_cnt_q <= '0;
            ext_pend_q <= 1'b0;
            brk_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            frame_q    <= frame_d;
            idle_cnt_q <= idle_cnt_d;
            ext_pend_q <= ext_pend_d;
            brk_pend_q <= brk_pend_d;
        end
    end

    // FIFO: pointers carry one extra bit so full and empty are distinct.
    logic [9:0]  mem_q [DEPTH];
    logic [AW:0] w_ptr_q, w_ptr_d, r_ptr_q, r_ptr_d;
    logic [AW:0] level, level_d;
    logic [9:0]  head_q, head_d;
    logic        full, empty, do_push, do_pop, ovf_set;
    logic        overflow_q, overflow_d, parity_err_q, parity_err_d, frame_err_q, frame_err_d;

    assign level   = w_ptr_q - r_ptr_q;
    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign do_pop  = rd_en_i & ~empty;
    assign do_push = push & (~full | do_pop);
    assign ovf_set = push & full & ~do_pop;
    assign w_ptr_d = w_ptr_q + (AW+1)'(do_push);
    assign r_ptr_d = r_ptr_q + (AW+1)'(do_pop);
    assign level_d = w_ptr_d - r_ptr_d;

    // Registered head; bypass the write when the next head slot is written this cycle.
    always_comb begin
        head_d = head_q;
        if (level_d != '0) begin
            if (do_push && (r_ptr_d[AW-1:0] == w_ptr_q[AW-1:0])) head_d = push_entry;
            else                                                  head_d = mem_q[r_ptr_d[AW-1:0]];
        end
    end

    // A set event wins over clr_err in the same cycle.
    assign overflow_d   = ovf_set | (overflow_q & ~clr_err_i);
    assign parity_err_d = par_set | (parity_err_q & ~clr_err_i);
    assign frame_err_d  = frm_set | (frame_err_q & ~clr_err_i);

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            w_ptr_q      <= '0;
            r_ptr_q      <= '0;
            head_q       <= '0;
            overflow_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            if (do_push) mem_q[w_ptr_q[AW-1:0]] <= push_entry;
            w_ptr_q      <= w_ptr_d;
            r_ptr_q      <= r_ptr_d;
            head_q       <= head_d;
            overflow_q   <= overflow_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign valid_o      = ~empty;
    assign level_o      = level;
    assign dout_o       = head_q[7:0];
    assign dout_brk_o   = head_q[8];
    assign dout_ext_o   = head_q[9];
    assign overflow_o   = overflow_q;
    assign parity_err_o = parity_err_q;
    assign frame_err_o  = frame_err_q;

endmodule
